// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: write-back handshake, register-file write port
// and the two forwarding lookup ports.
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              hold;

    logic              regwrite;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writedata;

    logic [CNT_W-1:0]  count;
    logic              empty;

    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              q1_hit;
    logic              q2_hit;
    logic [DATA_W-1:0] q1_data;
    logic [DATA_W-1:0] q2_data;

    // Pipeline / lookup side
    modport master (
        output in_valid, in_addr, in_data, hold, q1_addr, q2_addr,
        input  in_ready, regwrite, writereg, writedata, count, empty,
        input  q1_hit, q2_hit, q1_data, q2_data
    );

    // Queue side
    modport slave (
        input  in_valid, in_addr, in_data, hold, q1_addr, q2_addr,
        output in_ready, regwrite, writereg, writedata, count, empty,
        output q1_hit, q2_hit, q1_data, q2_data
    );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue feeding the register-file write port, one drain per cycle.
// Define WB_FWD_EN to build the youngest-match forwarding lookup on q1/q2.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_write_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic in_ready;
    logic accept;
    logic store;
    logic drain;

    // Full queue refuses input even if it drains this cycle: no bypass path.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign accept   = bus.in_valid && in_ready;
    assign store    = accept && (bus.in_addr != '0);
    assign drain    = (count_q != '0) && !bus.hold;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (drain) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            regwrite_d  = 1'b1;
            writereg_d  = addr_mem[rd_ptr_q];
            writedata_d = data_mem[rd_ptr_q];
        end

        case ({store, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    // Entry storage is deliberately left out of reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (rst_n && store) begin
            addr_mem[wr_ptr_q] <= bus.in_addr;
            data_mem[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.regwrite  = regwrite_q;
    assign bus.writereg  = writereg_q;
    assign bus.writedata = writedata_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0]  r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (a != '0) && (addr_mem[idx] == a)) begin
                r = {1'b1, data_mem[idx]};
            end
        end
        return r;
    endfunction

    assign {bus.q1_hit, bus.q1_data} = lookup(bus.q1_addr);
    assign {bus.q2_hit, bus.q2_data} = lookup(bus.q2_addr);
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{bus.q1_addr, bus.q2_addr};

    assign bus.q1_hit  = 1'b0;
    assign bus.q2_hit  = 1'b0;
    assign bus.q1_data = '0;
    assign bus.q2_data = '0;
`endif

endmodule
